wam_display_scan: RTL and testbench

//  Downstream of the whack-a-mole game core: consumes score, lives and state.

---
 rtl/wam_display_scan.sv | 202 ++++++++++++++++++++
 tb/tb_wam_display_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wam_display_scan.sv
// ---------------------------------------------------------------------------
// wam_display_scan
//   Scans the whack-a-mole status onto a 4-digit multiplexed seven-segment
//   display. Game-core inputs are sampled once per scan frame so that no digit
//   changes part way through a frame. On the end screen the score digits
//   blink.
//
//   Parameters
//     REFRESH_DIV  clk cycles per digit slot (4 slots per frame)
//     BLINK_DIV    frames per blink half-period
//     PULSE_FRAMES frames the d0 decimal point stays lit after a score gain
//
//   Ports
//     clk_i     system clock
//     reset_ni  asynchronous active-low reset
//     score_i   player score 0..15
//     lives_i   player lives 0..15
//     state_i   0 IDLE, 1 GAMEPLAY, 2 END_SCREEN, others illegal
//     an_o      digit anodes, active-low, an_o[3] = leftmost digit
//     seg_o     {g,f,e,d,c,b,a}, active-low
//     dp_o      decimal point, active-low
//
//   Optional feature macro: WAM_SCORE_PULSE_EN
//     When defined, a score increase seen at a frame boundary lights the d0
//     decimal point for PULSE_FRAMES frames. When undefined dp_o is always 1.
// ---------------------------------------------------------------------------
module wam_display_scan #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLINK_DIV    = 25,
    parameter int PULSE_FRAMES = 50
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [3:0] score_i,
    input  logic [3:0] lives_i,
    input  logic [2:0] state_i,
    output logic [3:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_END  = 3'd2;

    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    logic [3:0]    snap_score_q, snap_score_d;
    logic [3:0]    snap_lives_q, snap_lives_d;
    logic [2:0]    snap_state_q, snap_state_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       slot_wrap;
    logic       frame_end;
    logic       tens;
    logic [3:0] ones;

    // Scan timing and per-frame snapshot
    always_comb begin
        slot_wrap    = (slot_cnt_q == SW'(REFRESH_DIV - 1));
        frame_end    = slot_wrap && (idx_q == 2'd0);
        slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        // 2-bit index wraps 0 -> 3 on its own
        idx_d        = slot_wrap ? idx_q - 2'd1 : idx_q;
        snap_score_d = frame_end ? score_i : snap_score_q;
        snap_lives_d = frame_end ? lives_i : snap_lives_q;
        snap_state_d = frame_end ? state_i : snap_state_q;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        if (frame_end) begin
            if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

`ifdef WAM_SCORE_PULSE_EN
    localparam int PW = $clog2(PULSE_FRAMES + 1);

    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;

    // Compare the incoming score with the snapshot it is about to replace,
    // so only a genuine increase between frames re-arms the pulse.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (frame_end) begin
            if (score_i > snap_score_q)
                pulse_cnt_d = PW'(PULSE_FRAMES);
            else if (pulse_cnt_q != '0)
                pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) pulse_cnt_q <= '0;
        else           pulse_cnt_q <= pulse_cnt_d;
    end
`endif

    // Digit decode from the snapshot; an/seg/dp are all registered together
    // from the same idx so the anode never leads or trails its segments.
    always_comb begin
        tens  = (snap_score_q >= 4'd10);
        ones  = tens ? snap_score_q - 4'd10 : snap_score_q;
        an_d  = ~(4'b0001 << idx_q);
        seg_d = GLYPH_BLANK;
        case (snap_state_q)
            ST_IDLE: seg_d = GLYPH_DASH;
            ST_PLAY: begin
                case (idx_q)
                    2'd3:    seg_d = GLYPH_L;
                    2'd2:    seg_d = hex7(snap_lives_q);
                    2'd1:    seg_d = hex7({3'b000, tens});
                    default: seg_d = hex7(ones);
                endcase
            end
            ST_END: begin
                case (idx_q)
                    2'd3:    seg_d = GLYPH_E;
                    2'd2:    seg_d = GLYPH_BLANK;
                    2'd1:    seg_d = blink_q ? GLYPH_BLANK : hex7({3'b000, tens});
                    default: seg_d = blink_q ? GLYPH_BLANK : hex7(ones);
                endcase
            end
            default: seg_d = GLYPH_BLANK;
        endcase
`ifdef WAM_SCORE_PULSE_EN
        dp_d = !((idx_q == 2'd0) && (pulse_cnt_q != '0));
`else
        dp_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot_cnt_q   <= '0;
            idx_q        <= 2'd3;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            snap_score_q <= '0;
            snap_lives_q <= '0;
            snap_state_q <= ST_IDLE;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            snap_score_q <= snap_score_d;
            snap_lives_q <= snap_lives_d;
            snap_state_q <= snap_state_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_wam_display_scan.sv
module tb_wam_display_scan;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] score, lives;
    logic [2:0] state;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    wam_display_scan #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (2),
        .PULSE_FRAMES(3)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .score_i (score),
        .lives_i (lives),
        .state_i (state),
        .an_o    (an),
        .seg_o   (seg),
        .dp_o    (dp)
    );

    // d[3] is the leftmost digit
    typedef logic [3:0][6:0] dig_t;

    typedef struct {
        logic [2:0] st;
        logic [3:0] sc;
        logic [3:0] lv;
        dig_t       d;
        string      name;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference state: slot position within frame, blink phase, pulse
    int         pos_m;
    int         fc_m;
    bit         blink_m;
    int         pulse_m;
    logic [3:0] snap_m;

    task automatic model_reset();
        pos_m = 0; fc_m = 0; blink_m = 0; pulse_m = 0; snap_m = 4'd0;
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL %s got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                     name, an, seg, dp);
        end
    endtask

    task automatic run_slots(input int n, input dig_t exp, input bit blinkable,
                             input string name);
        int         idx;
        logic [3:0] one;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idx   = 3 - pos_m / 4;
            one   = 4'b0001;
            e_an  = ~(one << idx);
            e_seg = exp[idx];
            if (blinkable && blink_m && idx < 2) e_seg = 7'h7F;
            e_dp = 1'b1;
`ifdef WAM_SCORE_PULSE_EN
            if (idx == 0 && pulse_m != 0) e_dp = 1'b0;
`endif
            checks++;
            if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                errors++;
                $display("FAIL %s pos=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         name, pos_m, an, seg, dp, e_an, e_seg, e_dp);
            end
            pos_m++;
            if (pos_m == 16) begin
                // frame boundary: snapshot taken at this edge
                pos_m = 0;
                fc_m++;
                if (fc_m == 2) begin fc_m = 0; blink_m = ~blink_m; end
                if (score > snap_m)    pulse_m = 3;
                else if (pulse_m != 0) pulse_m--;
                snap_m = score;
            end
        end
    endtask

    vec_t tv[9];
    dig_t prev;
    bit   prev_b;
    dig_t dash, blank, g05, g06, g04, e09, g00;

    initial begin
        dash  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        blank = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
        tv[0] = '{3'd0, 4'd0,  4'd0,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "idle"};
        tv[1] = '{3'd1, 4'd12, 4'd3,  {7'h47, 7'h30, 7'h79, 7'h24}, "play_s12_l3"};
        tv[2] = '{3'd1, 4'd5,  4'd15, {7'h47, 7'h0E, 7'h40, 7'h12}, "play_s5_l15"};
        tv[3] = '{3'd1, 4'd6,  4'd10, {7'h47, 7'h08, 7'h40, 7'h02}, "play_s6_l10"};
        tv[4] = '{3'd1, 4'd15, 4'd0,  {7'h47, 7'h40, 7'h79, 7'h12}, "play_s15_l0"};
        tv[5] = '{3'd1, 4'd0,  4'd11, {7'h47, 7'h03, 7'h40, 7'h40}, "play_s0_l11"};
        tv[6] = '{3'd5, 4'd3,  4'd3,  {7'h7F, 7'h7F, 7'h7F, 7'h7F}, "illegal5"};
        tv[7] = '{3'd7, 4'd9,  4'd1,  {7'h7F, 7'h7F, 7'h7F, 7'h7F}, "illegal7"};
        tv[8] = '{3'd0, 4'd9,  4'd1,  {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "idle_again"};
        g05 = {7'h47, 7'h30, 7'h40, 7'h12};
        g06 = {7'h47, 7'h30, 7'h40, 7'h02};
        g04 = {7'h47, 7'h30, 7'h40, 7'h19};
        g00 = {7'h47, 7'h30, 7'h40, 7'h40};
        e09 = {7'h06, 7'h7F, 7'h40, 7'h10};

        // Reset values
        reset_n = 1'b0; state = 3'd0; score = 4'd0; lives = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_vals");
        reset_n = 1'b1;
        model_reset();
        prev = dash; prev_b = 0;

        // Table: each vector shows the old frame once (no tearing), then new
        foreach (tv[v]) begin
            state = tv[v].st; score = tv[v].sc; lives = tv[v].lv;
            run_slots(16, prev, prev_b, {tv[v].name, "_old"});
            run_slots(16, tv[v].d, 0, tv[v].name);
            prev = tv[v].d; prev_b = 0;
        end

        // Score change while idx=1 holds until the frame boundary
        state = 3'd1; score = 4'd5; lives = 4'd3;
        run_slots(16, prev, prev_b, "s05_old");
        run_slots(16, g05, 0, "s05");
        run_slots(10, g05, 0, "s05_pre");
        score = 4'd6;
        run_slots(6, g05, 0, "s05_hold");
        run_slots(16, g06, 0, "s06");

        // End screen blink, two frames each phase
        state = 3'd2; score = 4'd9;
        run_slots(16, g06, 0, "end_old");
        run_slots(64, e09, 1, "end_blink");
        prev = e09; prev_b = 1;

        // Illegal state, then reset pulsed mid-slot
        state = 3'd5;
        run_slots(16, prev, prev_b, "ill_old");
        run_slots(16, blank, 0, "ill");
        run_slots(6, blank, 0, "ill_pre_rst");
        #2 reset_n = 1'b0;
        #1 check_reset("async_reset");
        @(posedge clk); #1 check_reset("held_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        run_slots(16, dash, 0, "post_rst_idle");
        run_slots(16, blank, 0, "post_rst_ill");

        // Score pulse: increase lights d0 dp, decrease does not
        state = 3'd1; lives = 4'd3; score = 4'd4;
        run_slots(16, blank, 0, "p4_old");
        run_slots(16, g04, 0, "p4");
        score = 4'd5;
        run_slots(16, g04, 0, "p5_old");
        run_slots(64, g05, 0, "p5");
        score = 4'd0;
        run_slots(16, g05, 0, "p0_old");
        run_slots(32, g00, 0, "p0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
